// File: rtl/mem_block_bridge.sv
// Block-to-word bus bridge: splits one cache-block request into BEATS word beats,
// issues them in order under bus grant and reassembles the responses into a block.
module mem_block_bridge #(
  parameter int BLK_SIZE = 128,
  parameter int XLEN     = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  mem_req_valid_i,
  input  logic [31:0]           mem_req_addr_i,
  input  logic [BLK_SIZE/8-1:0] mem_req_rw_i,
  input  logic [BLK_SIZE-1:0]   mem_req_wdata_i,
  output logic                  mem_ready_o,
  output logic [BLK_SIZE-1:0]   mem_rdata_o,
  output logic                  bus_req_o,
  output logic [31:0]           bus_addr_o,
  output logic [3:0]            bus_we_o,
  output logic [XLEN-1:0]       bus_wdata_o,
  input  logic                  bus_gnt_i,
  input  logic                  bus_rvalid_i,
  input  logic [XLEN-1:0]       bus_rdata_i
);

  localparam int BEATS   = BLK_SIZE / XLEN;
  localparam int BOFFSET = $clog2(BLK_SIZE / 8);
  localparam int CW      = $clog2(BEATS + 1);
  localparam logic [CW-1:0] BEATS_C   = CW'(BEATS);
  localparam logic [31:0]   BOFF_MASK = 32'((1 << BOFFSET) - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t                state_q, state_d;
  logic [31:0]           base_q, base_d;
  logic [BLK_SIZE/8-1:0] rw_q, rw_d;
  logic [BLK_SIZE-1:0]   wdata_q, wdata_d;
  logic [CW-1:0]         issue_cnt_q, issue_cnt_d;
  logic [CW-1:0]         resp_cnt_q, resp_cnt_d;
  logic [BLK_SIZE-1:0]   rdata_q, rdata_d;
  logic                  mem_ready_q, mem_ready_d;
  logic                  bus_req_q, bus_req_d;
  logic [31:0]           bus_addr_q, bus_addr_d;
  logic [3:0]            bus_we_q, bus_we_d;
  logic [XLEN-1:0]       bus_wdata_q, bus_wdata_d;

  logic grant;
  int   nxt_idx;
  int   rsp_idx;

  assign grant = bus_req_q & bus_gnt_i;

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    rw_d        = rw_q;
    wdata_d     = wdata_q;
    issue_cnt_d = issue_cnt_q;
    resp_cnt_d  = resp_cnt_q;
    rdata_d     = rdata_q;
    mem_ready_d = 1'b0;
    bus_req_d   = bus_req_q;
    bus_addr_d  = bus_addr_q;
    bus_we_d    = bus_we_q;
    bus_wdata_d = bus_wdata_q;
    nxt_idx     = 0;
    rsp_idx     = int'(resp_cnt_q);
    case (state_q)
      IDLE: begin
        if (mem_req_valid_i) begin
          state_d     = ISSUE;
          base_d      = mem_req_addr_i & ~BOFF_MASK;
          rw_d        = mem_req_rw_i;
          wdata_d     = mem_req_wdata_i;
          issue_cnt_d = '0;
          resp_cnt_d  = '0;
          // Beat 0 is presented in the very first ISSUE cycle.
          bus_req_d   = 1'b1;
          bus_addr_d  = mem_req_addr_i & ~BOFF_MASK;
          bus_we_d    = mem_req_rw_i[3:0];
          bus_wdata_d = mem_req_wdata_i[XLEN-1:0];
        end
      end
      ISSUE: begin
        if (grant) begin
          issue_cnt_d = issue_cnt_q + 1'b1;
          nxt_idx     = int'(issue_cnt_d);
          if (issue_cnt_d == BEATS_C) begin
            bus_req_d = 1'b0;
          end else begin
            bus_addr_d  = base_q + (32'(issue_cnt_d) << 2);
            bus_we_d    = rw_q[4*nxt_idx +: 4];
            bus_wdata_d = wdata_q[XLEN*nxt_idx +: XLEN];
          end
        end
        // Responses fill lanes independently of issue; write beats count too.
        if (bus_rvalid_i) begin
          rdata_d[XLEN*rsp_idx +: XLEN] = bus_rdata_i;
          resp_cnt_d = resp_cnt_q + 1'b1;
          if (resp_cnt_d == BEATS_C) begin
            state_d     = DONE;
            mem_ready_d = 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      base_q      <= '0;
      rw_q        <= '0;
      wdata_q     <= '0;
      issue_cnt_q <= '0;
      resp_cnt_q  <= '0;
      rdata_q     <= '0;
      mem_ready_q <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_addr_q  <= '0;
      bus_we_q    <= '0;
      bus_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      rw_q        <= rw_d;
      wdata_q     <= wdata_d;
      issue_cnt_q <= issue_cnt_d;
      resp_cnt_q  <= resp_cnt_d;
      rdata_q     <= rdata_d;
      mem_ready_q <= mem_ready_d;
      bus_req_q   <= bus_req_d;
      bus_addr_q  <= bus_addr_d;
      bus_we_q    <= bus_we_d;
      bus_wdata_q <= bus_wdata_d;
    end
  end

  assign mem_ready_o = mem_ready_q;
  assign mem_rdata_o = rdata_q;
  assign bus_req_o   = bus_req_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_we_o    = bus_we_q;
  assign bus_wdata_o = bus_wdata_q;

endmodule

// File: tb/tb_mem_block_bridge.sv
// Directed bench for mem_block_bridge: a word-bus slave responder with configurable
// response latency and grant stall, plus hand-computed expected beats and blocks.
module tb_mem_block_bridge;

  logic         clk = 1'b0;
  logic         rst_ni;
  logic         mem_req_valid_i;
  logic [31:0]  mem_req_addr_i;
  logic [15:0]  mem_req_rw_i;
  logic [127:0] mem_req_wdata_i;
  logic         mem_ready_o;
  logic [127:0] mem_rdata_o;
  logic         bus_req_o;
  logic [31:0]  bus_addr_o;
  logic [3:0]   bus_we_o;
  logic [31:0]  bus_wdata_o;
  logic         bus_gnt_i;
  logic         bus_rvalid_i;
  logic [31:0]  bus_rdata_i;

  mem_block_bridge #(.BLK_SIZE(128), .XLEN(32)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .mem_req_valid_i(mem_req_valid_i), .mem_req_addr_i(mem_req_addr_i),
    .mem_req_rw_i(mem_req_rw_i), .mem_req_wdata_i(mem_req_wdata_i),
    .mem_ready_o(mem_ready_o), .mem_rdata_o(mem_rdata_o),
    .bus_req_o(bus_req_o), .bus_addr_o(bus_addr_o), .bus_we_o(bus_we_o),
    .bus_wdata_o(bus_wdata_o), .bus_gnt_i(bus_gnt_i),
    .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int cyc, lat, nbeats, ready_cnt, ready_cyc;
  int stall_beat, stall_left, stall_seen, stall_bad;
  logic [31:0] stall_addr;
  logic [31:0] rsp_pat [4];
  logic [31:0] b_addr [16];
  logic [3:0]  b_we   [16];
  logic [31:0] b_wd   [16];
  int          b_cyc  [16];
  int          due_q [$];
  logic [31:0] dat_q [$];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive slave inputs, sample at negedge, advance past posedge.
  task automatic tick();
    if (due_q.size() > 0 && due_q[0] <= cyc) begin
      bus_rvalid_i = 1'b1;
      bus_rdata_i  = dat_q[0];
    end else begin
      bus_rvalid_i = 1'b0;
      bus_rdata_i  = '0;
    end
    if (bus_req_o && nbeats == stall_beat && stall_left > 0) begin
      bus_gnt_i = 1'b0;
      stall_left--;
      stall_seen++;
      if (bus_addr_o !== stall_addr) stall_bad++;
    end else begin
      bus_gnt_i = 1'b1;
    end
    @(negedge clk);
    if (mem_ready_o) begin
      ready_cnt++;
      if (ready_cyc < 0) ready_cyc = cyc;
    end
    if (bus_req_o && bus_gnt_i && nbeats < 16) begin
      b_addr[nbeats] = bus_addr_o;
      b_we[nbeats]   = bus_we_o;
      b_wd[nbeats]   = bus_wdata_o;
      b_cyc[nbeats]  = cyc;
      due_q.push_back(cyc + lat);
      dat_q.push_back(rsp_pat[nbeats % 4]);
      nbeats++;
    end
    if (bus_rvalid_i) begin
      void'(due_q.pop_front());
      void'(dat_q.pop_front());
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic start_txn(input logic [31:0] addr, input logic [15:0] rw,
                           input logic [127:0] wd, input int latency);
    cyc = 0; lat = latency; nbeats = 0; ready_cnt = 0; ready_cyc = -1;
    stall_seen = 0; stall_bad = 0;
    due_q.delete(); dat_q.delete();
    mem_req_valid_i = 1'b1;
    mem_req_addr_i  = addr;
    mem_req_rw_i    = rw;
    mem_req_wdata_i = wd;
  endtask

  task automatic run_to_ready(input int budget);
    int n;
    n = 0;
    tick();
    mem_req_valid_i = 1'b0;
    while (ready_cnt == 0 && n < budget) begin
      tick();
      n++;
    end
    if (ready_cnt == 0) chk("ready_timeout", 0, 1);
  endtask

  initial begin
    rst_ni = 1'b0;
    mem_req_valid_i = 1'b0; mem_req_addr_i = '0; mem_req_rw_i = '0; mem_req_wdata_i = '0;
    bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = '0;
    stall_beat = -1; stall_left = 0; stall_addr = '0;
    cyc = 0; lat = 1; nbeats = 0; ready_cnt = 0; ready_cyc = -1;
    #3;
    chk("rst_ready", mem_ready_o, 0);
    chk("rst_req", bus_req_o, 0);
    chk("rst_addr", bus_addr_o, 0);
    chk("rst_we", bus_we_o, 0);
    chk("rst_wdata", bus_wdata_o, 0);
    chk("rst_rdata", mem_rdata_o, 0);
    @(posedge clk); #1;
    rst_ni = 1'b1;

    // Read of an unaligned address: beats walk the aligned block.
    rsp_pat = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    start_txn(32'h0000_1234, 16'h0, '0, 1);
    run_to_ready(30);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rd_addr%0d", k), b_addr[k], 32'h1230 + 32'(4 * k));
      chk($sformatf("rd_we%0d", k), b_we[k], 0);
    end
    chk("rd_ready_cyc", ready_cyc, 6);
    chk("rd_data", mem_rdata_o, 128'h44444444_33333333_22222222_11111111);
    tick(); tick();
    chk("rd_hold", mem_rdata_o, 128'h44444444_33333333_22222222_11111111);
    chk("rd_one_pulse", ready_cnt, 1);

    // Partial write: only lane 1 strobed.
    start_txn(32'h0000_0100, 16'h00F0,
              128'hCAFE0003_CAFE0002_DEADBEEF_CAFE0001, 1);
    run_to_ready(30);
    tick(); tick();
    chk("wr_we0", b_we[0], 4'h0);
    chk("wr_we1", b_we[1], 4'hF);
    chk("wr_we2", b_we[2], 4'h0);
    chk("wr_we3", b_we[3], 4'h0);
    chk("wr_wd1", b_wd[1], 32'hDEADBEEF);
    chk("wr_wd3", b_wd[3], 32'hCAFE0003);
    chk("wr_addr1", b_addr[1], 32'h104);
    chk("wr_one_pulse", ready_cnt, 1);

    // Grant stall of 3 cycles on beat 2.
    stall_beat = 2; stall_left = 3; stall_addr = 32'h408;
    start_txn(32'h0000_0400, 16'h0, '0, 1);
    run_to_ready(30);
    stall_beat = -1;
    chk("stall_cycles", stall_seen, 3);
    chk("stall_addr_held", stall_bad, 0);
    chk("stall_ready_cyc", ready_cyc, 9);
    chk("stall_addr2", b_addr[2], 32'h408);

    // Two-cycle response latency: grants and rvalids overlap.
    rsp_pat = '{32'hA0A0A0A0, 32'hA1A1A1A1, 32'hA2A2A2A2, 32'hA3A3A3A3};
    start_txn(32'h0000_0800, 16'h0, '0, 2);
    run_to_ready(30);
    chk("ovl_ready_cyc", ready_cyc, 7);
    chk("ovl_data", mem_rdata_o, 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0);

    // Reset after two grants, then a stray rvalid, then a clean read.
    rsp_pat = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    start_txn(32'h0000_0500, 16'h0, '0, 1);
    tick();
    mem_req_valid_i = 1'b0;
    tick(); tick();
    chk("rstm_grants", nbeats, 2);
    chk("rstm_req_before", bus_req_o, 1);
    rst_ni = 1'b0;
    #1;
    chk("rstm_req", bus_req_o, 0);
    chk("rstm_ready", mem_ready_o, 0);
    chk("rstm_rdata", mem_rdata_o, 0);
    @(negedge clk);
    rst_ni = 1'b1;
    due_q.delete(); dat_q.delete();
    @(posedge clk); #1;
    bus_rvalid_i = 1'b1; bus_rdata_i = 32'hBADBAD00; bus_gnt_i = 1'b1;
    @(posedge clk); #1;
    bus_rvalid_i = 1'b0; bus_rdata_i = '0;
    chk("stray_rdata", mem_rdata_o, 0);
    chk("stray_req", bus_req_o, 0);
    start_txn(32'h0000_0600, 16'h0, '0, 1);
    run_to_ready(30);
    chk("fresh_ready_cyc", ready_cyc, 6);
    chk("fresh_data", mem_rdata_o, 128'h44444444_33333333_22222222_11111111);

    // Back-to-back: valid held high, address changes mid-transaction.
    start_txn(32'h0000_2000, 16'h0, '0, 1);
    for (int n = 0; n < 30 && nbeats < 5; n++) begin
      if (cyc == 2) mem_req_addr_i = 32'h0000_3000;
      tick();
    end
    mem_req_valid_i = 1'b0;
    for (int k = 0; k < 4; k++)
      chk($sformatf("b2b_addr%0d", k), b_addr[k], 32'h2000 + 32'(4 * k));
    chk("b2b_ready_cyc", ready_cyc, 6);
    chk("b2b_second_cyc", b_cyc[4], 8);
    chk("b2b_second_addr", b_addr[4], 32'h3000);
    for (int n = 0; n < 20 && ready_cnt < 2; n++) tick();
    chk("b2b_two_pulses", ready_cnt, 2);
    chk("b2b_data", mem_rdata_o, 128'h44444444_33333333_22222222_11111111);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_block_bridge.md
MEM_BLOCK_BRIDGE -- requirements
Module: mem_block_bridge

Interface
REQ-001 SHALL have parameter BLK_SIZE, default 128, meaning cache block width in bits (multiple of 32, at least 64).
REQ-002 SHALL have parameter XLEN, default 32, meaning word-bus data width; BEATS = BLK_SIZE/XLEN and BOFFSET = log2(BLK_SIZE/8) are derived from it.
REQ-003 SHALL have port clk_i, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_ni, input, 1, meaning the reset; it is asynchronous and active-low.
REQ-005 SHALL have port mem_req_valid_i, input, 1, meaning a block request is present from the memory arbiter.
REQ-006 SHALL have port mem_req_addr_i, input, 32, meaning the block request address.
REQ-007 SHALL have port mem_req_rw_i, input, BLK_SIZE/8, meaning the byte write strobe; all-zero means read.
REQ-008 SHALL have port mem_req_wdata_i, input, BLK_SIZE, meaning the block write data.
REQ-009 SHALL have port mem_ready_o, output, 1, meaning a one-cycle completion pulse.
REQ-010 SHALL have port mem_rdata_o, output, BLK_SIZE, meaning the assembled block.
REQ-011 SHALL have port bus_req_o, output, 1, meaning a word-bus beat request.
REQ-012 SHALL have port bus_addr_o, output, 32, meaning the beat address.
REQ-013 SHALL have port bus_we_o, output, 4, meaning the beat byte strobe; 0 means read.
REQ-014 SHALL have port bus_wdata_o, output, XLEN, meaning the beat write data.
REQ-015 SHALL have port bus_gnt_i, input, 1, meaning the beat is accepted in a cycle where bus_req_o and bus_gnt_i are both 1.
REQ-016 SHALL have port bus_rvalid_i, input, 1, meaning a beat response, returned in grant order and at least one cycle after its grant.
REQ-017 SHALL have port bus_rdata_i, input, XLEN, meaning the beat response data.

Function
REQ-018 SHALL implement states IDLE, ISSUE and DONE.
REQ-019 In IDLE with mem_req_valid_i=1, the block SHALL latch the request and go to ISSUE at the next edge.
- Latched base = mem_req_addr_i with bits [BOFFSET-1:0] cleared.
- Latched values: rw mask and wdata.
- Issue and response counters cleared.
REQ-020 In ISSUE, bus_req_o SHALL be 1 while issue_cnt < BEATS.
- bus_addr_o = base + 4*issue_cnt, truncated to 32 bits.
- bus_we_o = rw[4*issue_cnt+3 : 4*issue_cnt].
- bus_wdata_o = wdata lane issue_cnt.
REQ-021 issue_cnt SHALL increment on each grant; bus_req_o SHALL drop in the cycle after the BEATS-th grant.
REQ-022 Each bus_rvalid_i in ISSUE SHALL write bus_rdata_i into mem_rdata_o lane resp_cnt (bits [XLEN*k+XLEN-1 : XLEN*k]) and increment resp_cnt; this applies to write beats too.
REQ-023 A grant and an rvalid in the same cycle SHALL both be counted.
REQ-024 When resp_cnt reaches BEATS, the block SHALL go to DONE.
REQ-025 In DONE, mem_ready_o SHALL be 1 for exactly one cycle, then the state returns to IDLE.
- No request is accepted in the DONE cycle.
REQ-026 mem_rdata_o SHALL hold its value from DONE until the next accepted request's first rvalid.
REQ-027 While not in IDLE, mem_req_* inputs SHALL be ignored (no re-latching).
REQ-028 bus_rvalid_i in IDLE or DONE SHALL be ignored.
REQ-029 Latency with bus_gnt_i held at 1 and rvalid one cycle after grant SHALL be:
- acceptance edge at cycle 0;
- grants in cycles 1..BEATS;
- mem_ready_o in cycle BEATS+2 (cycle 6 for BEATS=4).
REQ-030 bus_gnt_i low SHALL stall issue, with bus_req_o, bus_addr_o, bus_we_o and bus_wdata_o held stable until granted.

Reset
REQ-031 While rst_ni=0, the block SHALL asynchronously go to state IDLE.
- mem_ready_o=0, bus_req_o=0.
- bus_addr_o, bus_we_o, bus_wdata_o, mem_rdata_o and both counters = 0.
REQ-032 Reset asserted mid-transaction SHALL drop bus_req_o immediately and abandon the transaction; rvalids arriving after reset release in IDLE are ignored.
REQ-033 After rst_ni deasserts, the first request SHALL be accepted at the first rising edge on which mem_req_valid_i=1.

Verification
REQ-034 Read case:
- Stimulus: addr 0x0000_1234, rw=0, gnt=1, slave returns 0x11111111, 0x22222222, 0x33333333, 0x44444444 one cycle after each grant.
- Response: beat addresses 0x1230, 0x1234, 0x1238, 0x123C with bus_we_o=0; mem_ready_o in cycle 6; mem_rdata_o = 0x44444444_33333333_22222222_11111111.
REQ-035 Partial write case:
- Stimulus: addr 0x100, rw=0x00F0, wdata lane1 = 0xDEADBEEF.
- Response: beat 1 has bus_we_o=0xF and bus_wdata_o=0xDEADBEEF; beats 0, 2 and 3 have bus_we_o=0; exactly one mem_ready_o pulse.
REQ-036 Grant stall case:
- Stimulus: gnt low for 3 cycles on beat 2.
- Response: bus_addr_o stays base+8 throughout; completion is delayed by exactly 3 cycles.
REQ-037 Simultaneous grant and rvalid case:
- Stimulus: gnt=1 and rvalid in the same cycle, with multiple beats outstanding.
- Response: lanes filled in grant order; no lane skipped or overwritten.
REQ-038 Reset mid-transaction case:
- Stimulus: rst_ni pulled low after 2 grants.
- Response: bus_req_o=0 and mem_ready_o=0 without waiting for a clock edge; a later stray rvalid is ignored; a fresh read then completes correctly.
REQ-039 Back-to-back case:
- Stimulus: mem_req_valid_i held high across DONE.
- Response: the second request is accepted on the edge after DONE; the request is not re-latched during ISSUE.
